// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state/source encodings for the fetch-stage next-PC logic.
package fetch_pkg;
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI   = 32'h0000_6FFC;

    typedef enum logic {RUN, PEND} state_e;
    typedef enum logic {SRC_BR, SRC_ERET} src_e;
endpackage

// File: rtl/pc_addr_check.sv
// pc_addr_check: flags word-misaligned or out-of-text-range addresses.
//   addr : address under test
//   adel : 1 when addr is misaligned, below TEXT_LO or above TEXT_HI (unsigned)
module pc_addr_check
    import fetch_pkg::*;
(
    input  logic [31:0] addr,
    output logic        adel
);
    assign adel = (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC sequencer for the fetch stage.
//   clk, reset              : clock, asynchronous active-high reset
//   F_pc                    : current PC
//   stall                   : F/D stall request
//   D_br_take, D_br_target  : taken branch/jump resolved in D and its target
//   req                     : exception/interrupt accepted
//   eret, EPC               : eret committing and its return address
//   npc                     : value the PC loads at the next edge
//   pc_stall                : PC hold enable
//   FD_flush                : clears the F/D register
//   F_exc_adel              : fetch address error for F_pc
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_pc,
    input  logic        stall,
    input  logic        D_br_take,
    input  logic [31:0] D_br_target,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    output logic [31:0] npc,
    output logic        pc_stall,
    output logic        FD_flush,
    output logic        F_exc_adel
);
    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = F_pc + 32'd4;

    pc_addr_check u_chk (
        .addr(F_pc),
        .adel(F_exc_adel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            src_q   <= SRC_BR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        pend_d   = pend_q;
        npc      = pc_plus4;
        pc_stall = 1'b0;
        FD_flush = 1'b0;
        if (reset) begin
            npc = PC_RESET;
        end else if (req) begin
            // Exception entry beats stall and drops any held redirect.
            npc      = EXC_ENTRY;
            FD_flush = 1'b1;
            state_d  = RUN;
            src_d    = SRC_BR;
            pend_d   = '0;
        end else if (stall) begin
            pc_stall = 1'b1;
            if (eret) begin
                pend_d  = EPC;
                src_d   = SRC_ERET;
                state_d = PEND;
            end else if (D_br_take && (state_q == RUN || src_q == SRC_BR)) begin
                // A held eret is never displaced by a younger branch.
                pend_d  = D_br_target;
                src_d   = SRC_BR;
                state_d = PEND;
            end
        end else begin
            state_d = RUN;
            if (eret) begin
                npc      = EPC;
                FD_flush = 1'b1;
            end else if (D_br_take) begin
                npc = D_br_target;
            end else if (state_q == PEND) begin
                npc      = pend_q;
                FD_flush = (src_q == SRC_ERET);
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl.
module tb_fetch_ctrl;
    typedef struct {
        string       tag;
        logic [31:0] npc;
        logic        ps;
        logic        fl;
        logic        ad;
        bit          cn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] F_pc = 32'h3000;
    logic        stall = 1'b0;
    logic        D_br_take = 1'b0;
    logic [31:0] D_br_target = '0;
    logic        req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] EPC = '0;
    logic [31:0] npc;
    logic        pc_stall;
    logic        FD_flush;
    logic        F_exc_adel;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk),
        .reset(reset),
        .F_pc(F_pc),
        .stall(stall),
        .D_br_take(D_br_take),
        .D_br_target(D_br_target),
        .req(req),
        .eret(eret),
        .EPC(EPC),
        .npc(npc),
        .pc_stall(pc_stall),
        .FD_flush(FD_flush),
        .F_exc_adel(F_exc_adel)
    );

    task automatic step(input string tag, input logic rs, input logic st, input logic br,
                        input logic [31:0] bt, input logic rq, input logic er,
                        input logic [31:0] ep, input logic [31:0] fpc,
                        input bit cn, input logic [31:0] en, input logic eps,
                        input logic efl, input logic ead);
        exp_t e;
        reset = rs;
        stall = st;
        D_br_take = br;
        D_br_target = bt;
        req = rq;
        eret = er;
        EPC = ep;
        F_pc = fpc;
        q.push_back('{tag, en, eps, efl, ead, cn});
        @(negedge clk);
        e = q.pop_front();
        if (e.cn) begin
            total++;
            assert (npc === e.npc) else begin
                bad++;
                $error("FAIL %s npc got=%h exp=%h", e.tag, npc, e.npc);
            end
        end
        total++;
        assert (pc_stall === e.ps) else begin
            bad++;
            $error("FAIL %s pc_stall got=%b exp=%b", e.tag, pc_stall, e.ps);
        end
        total++;
        assert (FD_flush === e.fl) else begin
            bad++;
            $error("FAIL %s FD_flush got=%b exp=%b", e.tag, FD_flush, e.fl);
        end
        total++;
        assert (F_exc_adel === e.ad) else begin
            bad++;
            $error("FAIL %s F_exc_adel got=%b exp=%b", e.tag, F_exc_adel, e.ad);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //    tag          rs st br target     rq er EPC        F_pc        cn npc        ps fl ad
        step("reset",      1, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3000,    1, 32'h3000,  0, 0, 0);
        step("seq",        0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3000,    1, 32'h3004,  0, 0, 0);
        step("st_br",      0, 1, 1, 32'h3040, 0, 0, 32'h0,    32'h3004,    1, 32'h3008,  1, 0, 0);
        step("st2",        0, 1, 0, 32'h0,    0, 0, 32'h0,    32'h3004,    0, 32'h0,     1, 0, 0);
        step("st3",        0, 1, 0, 32'h0,    0, 0, 32'h0,    32'h3004,    0, 32'h0,     1, 0, 0);
        step("pend_br",    0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3004,    1, 32'h3040,  0, 0, 0);
        step("after_pend", 0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3040,    1, 32'h3044,  0, 0, 0);
        step("st_br2",     0, 1, 1, 32'h3040, 0, 0, 32'h0,    32'h3044,    0, 32'h0,     1, 0, 0);
        step("st_eret",    0, 1, 0, 32'h0,    0, 1, 32'h3100, 32'h3044,    0, 32'h0,     1, 0, 0);
        step("st_br_keep", 0, 1, 1, 32'h3200, 0, 0, 32'h0,    32'h3044,    0, 32'h0,     1, 0, 0);
        step("pend_eret",  0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3044,    1, 32'h3100,  0, 1, 0);
        step("st_br3",     0, 1, 1, 32'h3040, 0, 0, 32'h0,    32'h3100,    0, 32'h0,     1, 0, 0);
        step("req_pend",   0, 1, 0, 32'h0,    1, 0, 32'h0,    32'h3100,    1, 32'h4180,  0, 1, 0);
        step("post_req",   0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h4180,    1, 32'h4184,  0, 0, 0);
        step("req_run_st", 0, 1, 1, 32'h3300, 1, 1, 32'h3500, 32'h4184,    1, 32'h4180,  0, 1, 0);
        step("mis",        0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3002,    1, 32'h3006,  0, 0, 1);
        step("low",        0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h2FFC,    1, 32'h3000,  0, 0, 1);
        step("high",       0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h7000,    1, 32'h7004,  0, 0, 1);
        step("top_ok",     0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h6FFC,    1, 32'h7000,  0, 0, 0);
        step("wrap",       0, 0, 0, 32'h0,    0, 0, 32'h0,    32'hFFFFFFFC, 1, 32'h0,    0, 0, 1);
        step("eret_br",    0, 0, 1, 32'h3300, 0, 1, 32'h3500, 32'h3000,    1, 32'h3500,  0, 1, 0);
        step("br_only",    0, 0, 1, 32'h3300, 0, 0, 32'h0,    32'h3000,    1, 32'h3300,  0, 0, 0);
        step("st_br4",     0, 1, 1, 32'h3040, 0, 0, 32'h0,    32'h3300,    0, 32'h0,     1, 0, 0);
        step("pend_new",   0, 0, 1, 32'h3400, 0, 0, 32'h0,    32'h3300,    1, 32'h3400,  0, 0, 0);
        step("st_br5",     0, 1, 1, 32'h3040, 0, 0, 32'h0,    32'h3400,    0, 32'h0,     1, 0, 0);
        step("rst_pend",   1, 1, 0, 32'h0,    0, 0, 32'h0,    32'h3400,    1, 32'h3000,  0, 0, 0);
        step("no_replay",  0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h3000,    1, 32'h3004,  0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC sequencer for the fetch stage of the five-stage MIPS pipeline. It selects the value loaded into the PC register each cycle: sequential PC+4, the D-stage branch/jump target, the exception entry vector, or EPC on `eret`. It also generates the PC hold signal, and holds a redirect that arrives while fetch is stalled until the stall clears. It flags misaligned or out-of-range fetch addresses, and it drives the F/D flush on exception entry and `eret`.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value after reset
- `EXC_ENTRY`, 32'h0000_4180, exception/interrupt handler vector
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address
- `TEXT_HI`, 32'h0000_6FFC, highest legal fetch address
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `F_pc` in 32: current PC register output.
- `stall` in 1: hazard-unit stall request for F/D.
- `D_br_take` in 1: branch/jump resolved taken in D.
- `D_br_target` in 32: target for `D_br_take`.
- `req` in 1: exception/interrupt accepted (from CP0).
- `eret` in 1: `eret` committing.
- `EPC` in 32: return address for `eret`.
- `npc` out 32: value the PC loads at the next edge.
- `pc_stall` out 1: PC hold enable.
- `FD_flush` out 1: clears the F/D register.
- `F_exc_adel` out 1: fetch address error for `F_pc`.

## Operation
- Redirect priority: `req` > `eret` > `D_br_take` > pending redirect > sequential.
- State `RUN`:
  - `stall`=0: `npc` = highest-priority redirect target, else `F_pc`+4. `pc_stall`=0.
  - `stall`=1 with `eret` or `D_br_take` asserted (and no `req`): latch the target into `pend_target` and go to `PEND`. `pc_stall`=1.
  - `stall`=1 with no redirect: `pc_stall`=1 and `npc` = `F_pc`+4 (ignored by the PC).
- State `PEND`:
  - While `stall`=1: `pc_stall`=1.
  - An `eret` overwrites `pend_target` with EPC.
  - A `D_br_take` overwrites `pend_target` only if the pending entry came from a branch.
  - When `stall`=0: `npc` = `pend_target`, `pc_stall`=0, return to `RUN`. If a new redirect arrives in that same cycle, the new redirect wins.
- `req`, in any state: overrides `stall`. `npc`=`EXC_ENTRY`, `pc_stall`=0, `FD_flush`=1, pending entry discarded, next state `RUN`.
- `eret` applied, meaning it drives `npc` either directly or from `PEND`: `FD_flush`=1. A branch redirect never asserts `FD_flush`.
- `F_exc_adel`=1 iff `F_pc[1:0]`≠0, or `F_pc` < `TEXT_LO`, or `F_pc` > `TEXT_HI` (unsigned compare). This is a pure function of `F_pc` and is independent of state.
- Arithmetic: `F_pc`+4 is 32-bit modulo, so wrap is allowed and gets flagged on the next fetch by `F_exc_adel`.

## Timing
- `npc`, `pc_stall` and `FD_flush` are combinational from the inputs and the state; the PC updates at the following rising edge (redirect latency is 1 cycle).
- Reset values, while `reset`=1:
  - State `RUN`, `pend_target`=0, pending-source flag cleared.
  - `npc`=`PC_RESET`, `pc_stall`=0, `FD_flush`=0.
- A reset asserted mid-`PEND` drops the pending redirect with no replay.
- Only state, `pend_target` and the pending-source flag are registered. They update on the `clk` rising edge and asynchronously on `reset`.
- `req` and `stall` high together: the redirect is taken the same cycle, so no stall cycle is lost.

## Structure
- Shared package `fetch_pkg`:
  - `PC_RESET`, `EXC_ENTRY`, `TEXT_LO`, `TEXT_HI` constants.
  - State enum {`RUN`, `PEND`}.
  - Pending-source enum {`SRC_BR`, `SRC_ERET`}.
- Sub-module `pc_addr_check`: combinational range/alignment check producing `F_exc_adel`. It is reused by the data-address checker.

## Test plan
- Reset release with `F_pc`=0x3000 and no inputs: `npc`=0x3004, `pc_stall`=0, `F_exc_adel`=0.
- `stall`=1 for 3 cycles, with `D_br_take`=1 and `D_br_target`=0x3040 in the first cycle only: `pc_stall`=1 for 3 cycles, then `npc`=0x3040 in the first unstalled cycle.
- In `PEND` (branch 0x3040) apply `eret` with `EPC`=0x3100 while stalled, then release the stall: `npc`=0x3100 and `FD_flush`=1 for that cycle.
- `req`=1 with `stall`=1 in `PEND`: `npc`=0x4180, `pc_stall`=0, `FD_flush`=1, next state `RUN`, pending entry discarded.
- `F_pc`=0x3002, 0x2FFC, 0x7000 → `F_exc_adel`=1 each. `F_pc`=0x6FFC → `F_exc_adel`=0.
- Assert `reset` mid-`PEND`: outputs go immediately to `npc`=0x3000 and `pc_stall`=0; after release, no stale redirect appears.
